// File: rtl/bcd_scan_pkg.sv
// Shared constants for the BCD scan display: segment patterns and nibble limits.
// Segment encoding is {g,f,e,d,c,b,a}, active-high.
package bcd_scan_pkg;

    localparam int NIB_W = 4;
    localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] digit_seg(input logic [NIB_W-1:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Bus bundle between the BCD counter datapath and the scan display driver.
// The master drives load/bcd_in; the slave drives the display pins and status.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    import bcd_scan_pkg::*;

    logic                      load;
    logic [NIB_W*DIGITS-1:0]   bcd_in;
    logic [6:0]                seg;
    logic [DIGITS-1:0]         an;
    logic                      err;
    logic                      frame_done;

    modport master (
        output load, bcd_in,
        input  seg, an, err, frame_done
    );

    modport slave (
        input  load, bcd_in,
        output seg, an, err, frame_done
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational nibble to seven-segment decoder with blanking.
// Nibbles above 9 decode to the letter E.
module bcd_to_seg
    import bcd_scan_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    input  logic             blank,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (1'b1)
            blank:                   seg = SEG_BLANK;
            (!blank && nib > BCD_MAX): seg = SEG_E;
            default:                 seg = digit_seg(nib);
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Tear-free multiplexed seven-segment scanner for packed BCD digits.
// Optional leading-zero blanking: define BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_display
    import bcd_scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset,
    bcd_scan_display_if.slave bus
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = NIB_W * DIGITS;

    localparam logic [DW-1:0]     DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

    logic [DW-1:0]     div;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     shadow;
    logic [BW-1:0]     visible;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    logic              err_q;
    logic              fd_q;

    logic [NIB_W-1:0]  nib [DIGITS];
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] bad;
    logic [NIB_W-1:0]  cur_nib;
    logic              cur_blank;
    logic [6:0]        seg_d;
    logic              last_div;
    logic              wrap;

    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
        assign nib[k] = visible[k*NIB_W +: NIB_W];
        assign bad[k] = bus.bcd_in[k*NIB_W +: NIB_W] > BCD_MAX;
    end

`ifdef BCD_SCAN_LZ_BLANK_EN
    // A digit blanks when it and every digit above it are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        if (k == 0) begin : g_lsd
            assign blank[k] = 1'b0;
        end else begin : g_upper
            assign blank[k] = (visible[BW-1:k*NIB_W] == '0);
        end
    end
`else
    assign blank = '0;
`endif

    assign cur_nib   = nib[idx];
    assign cur_blank = blank[idx];

    bcd_to_seg u_seg (
        .nib   (cur_nib),
        .blank (cur_blank),
        .seg   (seg_d)
    );

    assign last_div = (div == DIV_LAST);
    assign wrap     = last_div && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            idx     <= '0;
            shadow  <= '0;
            visible <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            div <= last_div ? '0 : div + DW'(1);
            if (last_div)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            // Promotion reads shadow before any same-edge load lands.
            if (wrap)
                visible <= shadow;
            if (bus.load) begin
                shadow <= bus.bcd_in;
                err_q  <= |bad;
            end
            fd_q  <= wrap;
            an_q  <= (div == '0) ? '0 : (AN_ONE << idx);
            seg_q <= (div == '0) ? SEG_BLANK : seg_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.err        = err_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display, DIGITS=4 REFRESH_DIV=4 (16-cycle frame).
// Define BCD_SCAN_LZ_BLANK_EN for both DUT and bench to test blanking.
module tb_bcd_scan_display;

    localparam int DIGITS = 4;
    localparam int RDIV   = 4;
    localparam int FRAME  = DIGITS * RDIV;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       err;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    bcd_scan_display_if #(.DIGITS(DIGITS)) bus ();

    bcd_scan_display #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    exp_t exp_q[$];

    int          m_pos;
    logic [15:0] m_shadow;
    logic [15:0] m_vis;
    bit          m_err;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, want, $time);
    endtask

    function automatic logic [6:0] seg_for(input int d, input logic [15:0] v);
        int n;
        n = (v >> (4 * d)) & 15;
`ifdef BCD_SCAN_LZ_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 0) return 7'h00;
`endif
        if (n > 9) return 7'h79;
        return seg_tab[n];
    endfunction

    function automatic bit any_bad(input logic [15:0] v);
        for (int k = 0; k < DIGITS; k++)
            if (((v >> (4 * k)) & 15) > 9) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs after one clock edge, from the frame position before it.
    task automatic model(input bit rs, input bit ld, input logic [15:0] v);
        exp_t e;
        int d, sub;
        if (rs) begin
            e = '{seg: 7'h00, an: 4'h0, err: 1'b0, fd: 1'b0};
            m_pos = 0; m_shadow = '0; m_vis = '0; m_err = 1'b0;
        end else begin
            d   = m_pos / RDIV;
            sub = m_pos % RDIV;
            e.an  = (sub == 0) ? 4'h0 : 4'(1 << d);
            e.seg = (sub == 0) ? 7'h00 : seg_for(d, m_vis);
            e.fd  = (m_pos == FRAME - 1);
            if (m_pos == FRAME - 1) m_vis = m_shadow;
            if (ld) begin
                m_shadow = v;
                m_err    = any_bad(v);
            end
            e.err = m_err;
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rs, input bit ld, input logic [15:0] v);
        reset      = rs;
        bus.load   = ld;
        bus.bcd_in = v;
        @(posedge clk);
        model(rs, ld, v);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && m_pos != pos; i++)
            step(1'b0, 1'b0, 16'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an", int'(bus.an), int'(e.an));
            if (e.an != 4'h0) chk("seg", int'(bus.seg), int'(e.seg));
            chk("err", int'(bus.err), int'(e.err));
            chk("frame_done", int'(bus.frame_done), int'(e.fd));
        end
    end

    initial begin
        logic [15:0] v;
        m_pos = 0; m_shadow = '0; m_vis = '0; m_err = 1'b0;

        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        idle(2 * FRAME + 3);

        run_to(6);
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME + 2);

        step(1'b0, 1'b1, 16'h00A5);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0005);
        idle(FRAME);

        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h9999);
        idle(2 * FRAME + 1);

        step(1'b0, 1'b1, 16'h0070);
        idle(2 * FRAME);

        run_to(1);
        step(1'b0, 1'b1, 16'h5555);
        run_to(9);
        step(1'b1, 1'b0, 16'h0);
        idle(FRAME + 2);

        for (int i = 0; i < 400; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                for (int k = 0; k < DIGITS; k++)
                    v[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 3) == 0)
                v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0), v);
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment driver that consumes packed BCD digits from the `bcd_counters` family and scans them onto a common-segment multi-digit display. A new value is captured into a shadow register on `load` and promoted to the visible register only at a frame boundary, so digits never tear. Nibbles above 9 are flagged and shown as `E`. It sits between the counter datapath and the board display pins.

## Interface
- `DIGITS`, 4: number of BCD digits scanned. Minimum 1.
- `REFRESH_DIV`, 1000: clock cycles per digit slot. Minimum 2.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `load`, input, 1: capture `bcd_in` into the shadow register this cycle.
- `bcd_in`, input, 4*DIGITS: packed BCD. Digit 0 is `[3:0]` and is the least significant.
- `seg`, output, 7: `{g,f,e,d,c,b,a}`, active-high.
- `an`, output, DIGITS: one-hot digit enable, active-high.
- `err`, output, 1: last captured value contained a nibble > 9.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- **Slot state**
  - `div` counts 0..REFRESH_DIV-1 and `idx` counts 0..DIGITS-1.
  - When `div`==REFRESH_DIV-1: `div`→0, `idx`→`idx`+1, wrapping DIGITS-1→0.
- **Dead time:** while `div`==0 the slot drives `an`=0 (anti-ghosting). For `div`≥1 it drives one-hot `an[idx]` and `seg`=pattern(visible digit `idx`).
- **Patterns (hex)**
  - Digits 0-9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Invalid nibble (>9): 79 (`E`).
  - Blank: 00.
- **Capture:** `load`=1 writes `bcd_in` to `shadow`.
  - At the same edge, `err` is set to 1 if any nibble is > 9, otherwise to 0.
  - `err` holds its value between loads.
- **Promotion:** at the wrap edge (`div`==REFRESH_DIV-1 and `idx`==DIGITS-1), `visible` ← `shadow`.
- **Load and wrap in the same cycle:** promotion uses the pre-load `shadow` contents. The new value is shown one frame later.
- **`frame_done`:** registered. It is high for exactly the cycle following the wrap edge.

## Timing
- **Reset values:** `seg`=0, `an`=0, `err`=0, `frame_done`=0, `div`=0, `idx`=0, `shadow`=0, `visible`=0.
- **Output registers:** `seg` and `an` are registered. Each edge loads them from the slot state (`div`, `idx`, `visible`) as it was before that edge, so outputs lag slot state by 1 cycle.
- **First cycle after reset release:** outputs are still 0.
- **Frame length:** DIGITS×REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-1 cycles, preceded by 1 dark cycle.
- **Load-to-display latency:** from a `load` edge to first visible use is at most 2 frames + 1 cycle, and at least 1 cycle + 1 (dead) cycle.
- **Reset mid-frame:** all state clears at that edge and scanning restarts from `idx`=0, `div`=0. A pending `shadow` value is discarded.
- **`load` while `reset`=1:** ignored.

## Configuration
- `BCD_SCAN_LZ_BLANK_EN`
  - **Defined:** leading-zero blanking. Any `visible` digit k>0 that is 0, with all digits above k also 0, is shown as blank (`seg`=00). `an` still asserts normally. Digit 0 is never blanked. An invalid nibble stops the blanking run.
  - **Undefined:** every digit shows its pattern. The blanking logic is absent.

## Structure
- **Shared package `bcd_scan_pkg`:**
  - Segment-pattern constants `SEG_0`..`SEG_9`, `SEG_E`, `SEG_BLANK`.
  - `BCD_MAX` = 9.
  - Nibble width constant, 4.
- **Sub-module `bcd_to_seg`:** purely combinational, 4-bit nibble plus `blank` in, 7-bit `seg` out. It performs the invalid-nibble → `SEG_E` mapping.
- **Top level:** owns the counters, shadow/visible registers, blanking-run logic and output registers.

## Test plan
All tests use DIGITS=4 and REFRESH_DIV=4, giving a 16-cycle frame.
1. **Reset scan:** assert reset for 2 cycles, then release → all outputs 0 during reset. Then `an` cycles 0000 → 0001×3 → 0000 → 0010×3 … with `seg`=3F whenever lit (macro off). `frame_done` pulses every 16 cycles.
2. **Tear-free load:** `load` 16'h1234 mid-frame → the rest of the current frame still shows 0. After the next `frame_done`: `an`=0001 gives `seg`=66, 0010 gives 4F, 0100 gives 5B, 1000 gives 06.
3. **Error flag:** `load` 16'h00A5 → `err`=1 next cycle, and after promotion digit 1 shows 79. Then `load` 16'h0005 → `err`=0.
4. **Load on wrap edge:** `load` 16'h9999 on the exact wrap-edge cycle → the next frame shows the old value. The frame after that shows `seg`=6F on all digits.
5. **Leading-zero blanking:** `load` 16'h0070 with macro defined → digits 3 and 2 give `seg`=00 with `an` still asserted, digit 1 gives 07, digit 0 gives 3F. Macro undefined → digits 3, 2 and 0 give 3F.
6. **Reset mid-frame:** assert reset at `idx`=2 with `shadow` holding 16'h5555 → outputs 0 next cycle, `err`=0, and the scan restarts at digit 0 showing 3F.
